// File: rtl/io_uart_core_if.sv
// IO-bus slot interface for the UART responder.
//
// Strobe semantics: the bus has no valid/ready back-pressure. A cycle
// with cs & rd_en is a read and cs & wr_en is a write. Both complete in
// the cycle they are presented. Read data appears on uart_rd_data after
// the following clock edge and holds until the next read.
interface io_uart_core_if;
  logic        rd_en;
  logic        wr_en;
  logic        cs;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] uart_rd_data;

  modport master (
    output rd_en, wr_en, cs, address, wr_data,
    input  uart_rd_data
  );

  modport slave (
    input  rd_en, wr_en, cs, address, wr_data,
    output uart_rd_data
  );
endinterface

// File: rtl/io_uart_core.sv
// io_uart_core: UART responder on the IO bus (slot 2).
// Register map at address[3:2]: 0 DATA, 1 STATUS, 2 BAUD, 3 CTRL.
// Optional even-parity framing is enabled by defining UART_PARITY_EN.
module io_uart_core #(
  parameter int TX_FIFO_DEPTH    = 8,
  parameter int DEFAULT_BAUD_DIV = 868
) (
  input  logic          clk,
  input  logic          rst,
  io_uart_core_if.slave io_bus_s,
  output logic          uart_tx,
  input  logic          uart_rx
);

  localparam int AW = $clog2(TX_FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Bus decode
  logic       rd_sel, wr_sel;
  logic [1:0] reg_idx;
  logic       unused_bits;
  assign rd_sel  = io_bus_s.rd_en & io_bus_s.cs;
  assign wr_sel  = io_bus_s.wr_en & io_bus_s.cs;
  assign reg_idx = io_bus_s.address[3:2];
  assign unused_bits = ^{io_bus_s.address[31:4], io_bus_s.address[1:0],
                         io_bus_s.wr_data[31:16]};

  logic data_wr, baud_wr, ctrl_wr, data_rd;
  assign data_wr = wr_sel && (reg_idx == 2'd0);
  assign baud_wr = wr_sel && (reg_idx == 2'd2);
  assign ctrl_wr = wr_sel && (reg_idx == 2'd3);
  assign data_rd = rd_sel && (reg_idx == 2'd0);

  logic [15:0] baud_div;

  // TX FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, push;
  logic [7:0]  fifo_head;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = data_wr && !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];

  // TX shifter state
  logic [2:0]  tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_idx;
  logic        tx_par;
  logic        tx_bit_end, tx_load, tx_busy;
  assign tx_bit_end = (tx_cnt == 16'd0);
  // A new frame is loaded from idle, or straight out of a finished stop bit.
  assign tx_load = !fifo_empty &&
                   ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_bit_end));
  assign tx_busy = (tx_state != S_IDLE);

  // FIFO data array: written on an accepted push
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= io_bus_s.wr_data[7:0];
  end

  // FIFO pointers: push from bus, pop when the shifter loads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (tx_load) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Baud divisor register, clamped so every bit lasts at least 4 clocks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) baud_div <= 16'(DEFAULT_BAUD_DIV);
    else if (baud_wr)
      baud_div <= (io_bus_s.wr_data[15:0] < 16'd4) ? 16'd4 : io_bus_s.wr_data[15:0];
  end

  // TX FSM: the divisor is latched at frame start so BAUD writes wait a frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_shift <= '0;
      tx_idx   <= '0;
      tx_par   <= 1'b0;
    end else if (tx_load) begin
      tx_state <= S_START;
      tx_shift <= fifo_head;
      tx_par   <= ^fifo_head;
      tx_div   <= baud_div;
      tx_cnt   <= baud_div - 16'd1;
    end else begin
      case (tx_state)
        S_START: begin
          if (tx_bit_end) begin
            tx_state <= S_DATA;
            tx_cnt   <= tx_div - 16'd1;
            tx_idx   <= '0;
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_cnt   <= tx_div - 16'd1;
            tx_idx   <= tx_idx + 3'd1;
`ifdef UART_PARITY_EN
            if (tx_idx == 3'd7) tx_state <= S_PARITY;
`else
            if (tx_idx == 3'd7) tx_state <= S_STOP;
`endif
          end else tx_cnt <= tx_cnt - 16'd1;
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (tx_bit_end) begin
            tx_state <= S_STOP;
            tx_cnt   <= tx_div - 16'd1;
          end else tx_cnt <= tx_cnt - 16'd1;
        end
`endif
        S_STOP: begin
          if (tx_bit_end) tx_state <= S_IDLE;
          else tx_cnt <= tx_cnt - 16'd1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Line driver decoded from TX state; reset forces the idle-high level
  always_comb begin
    uart_tx = 1'b1;
    case (tx_state)
      S_START:  uart_tx = 1'b0;
      S_DATA:   uart_tx = tx_shift[0];
`ifdef UART_PARITY_EN
      S_PARITY: uart_tx = tx_par;
`endif
      default:  uart_tx = 1'b1;
    endcase
  end

  // RX synchroniser plus a delayed copy for falling-edge detection
  logic rx_meta, rx_s, rx_last;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_last <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_last <= rx_s;
    end
  end

  logic [2:0]  rx_state;
  logic [15:0] rx_cnt, rx_div;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_idx;
  logic        rx_sample, rx_done;
  assign rx_sample = (rx_cnt == 16'd0);

`ifdef UART_PARITY_EN
  logic rx_par_ok, rx_par_bad;
  assign rx_par_bad = (rx_state == S_PARITY) && rx_sample && (rx_s != ^rx_shift);
  assign rx_done    = (rx_state == S_STOP) && rx_sample && rx_s && rx_par_ok;
`else
  assign rx_done    = (rx_state == S_STOP) && rx_sample && rx_s;
`endif

  // RX FSM: start bit re-checked at mid-bit, then one sample per bit period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_shift <= '0;
      rx_idx   <= '0;
`ifdef UART_PARITY_EN
      rx_par_ok <= 1'b1;
`endif
    end else begin
      case (rx_state)
        S_START: begin
          if (rx_sample) begin
            if (rx_s) rx_state <= S_IDLE;
            else begin
              rx_state <= S_DATA;
              rx_cnt   <= rx_div - 16'd1;
              rx_idx   <= '0;
            end
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        S_DATA: begin
          if (rx_sample) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_cnt   <= rx_div - 16'd1;
            rx_idx   <= rx_idx + 3'd1;
`ifdef UART_PARITY_EN
            if (rx_idx == 3'd7) rx_state <= S_PARITY;
`else
            if (rx_idx == 3'd7) rx_state <= S_STOP;
`endif
          end else rx_cnt <= rx_cnt - 16'd1;
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (rx_sample) begin
            rx_par_ok <= !rx_par_bad;
            rx_state  <= S_STOP;
            rx_cnt    <= rx_div - 16'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
`endif
        S_STOP: begin
          if (rx_sample) rx_state <= S_IDLE;
          else rx_cnt <= rx_cnt - 16'd1;
        end
        default: begin
          if (rx_last && !rx_s) begin
            rx_state <= S_START;
            rx_div   <= baud_div;
            rx_cnt   <= (baud_div >> 1) - 16'd1;
          end
        end
      endcase
    end
  end

  // Receive holding register and sticky error flags
  logic [7:0] rx_byte;
  logic       rx_valid, rx_overrun, par_err_bit;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_done) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (data_rd) rx_valid <= 1'b0;
      if (rx_done && rx_valid) rx_overrun <= 1'b1;
      else if (ctrl_wr && io_bus_s.wr_data[0]) rx_overrun <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  logic rx_par_err;
  // Parity error flag: set on mismatch, cleared by CTRL bit1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_par_err <= 1'b0;
    else if (rx_par_bad) rx_par_err <= 1'b1;
    else if (ctrl_wr && io_bus_s.wr_data[1]) rx_par_err <= 1'b0;
  end
  assign par_err_bit = rx_par_err;
`else
  assign par_err_bit = 1'b0;
`endif

  logic [31:0] status;
  assign status = {26'b0, par_err_bit, tx_busy, rx_overrun, rx_valid,
                   fifo_empty && !tx_busy, fifo_full};

  // Registered read mux: values are those before any same-cycle write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) io_bus_s.uart_rd_data <= '0;
    else if (rd_sel) begin
      case (reg_idx)
        2'd0:    io_bus_s.uart_rd_data <= {24'b0, rx_byte};
        2'd1:    io_bus_s.uart_rd_data <= status;
        2'd2:    io_bus_s.uart_rd_data <= {16'b0, baud_div};
        default: io_bus_s.uart_rd_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_core.sv
// Testbench for io_uart_core (default 8N1 build, 16 clocks per bit).
module tb_io_uart_core;

  localparam int BIT = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  logic uart_tx, uart_rx;
  always #5 clk = ~clk;

  io_uart_core_if io_bus ();

  io_uart_core #(.TX_FIFO_DEPTH(8), .DEFAULT_BAUD_DIV(868)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_bus_s (io_bus),
    .uart_tx  (uart_tx),
    .uart_rx  (uart_rx)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] prev_rd;

  typedef struct {
    logic        rd;
    logic        cs;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic rd, input logic cs, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp,
                              input string name);
    vec_t v;
    v.rd = rd; v.cs = cs; v.addr = addr; v.wdata = wdata; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Driver tasks: every task starts and ends 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic cs);
    io_bus.rd_en   = rd;
    io_bus.wr_en   = wr;
    io_bus.cs      = cs;
    io_bus.address = addr;
    io_bus.wr_data = wd;
    tick();
    io_bus.rd_en   = 1'b0;
    io_bus.wr_en   = 1'b0;
    io_bus.cs      = 1'b0;
    io_bus.address = '0;
    io_bus.wr_data = '0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd);
    bus_cycle(1'b0, 1'b1, addr, wd, 1'b1);
  endtask

  // Read (optionally with simultaneous write); checks the old value holds
  // up to the edge, then the scoreboard entry against the new value.
  task automatic bus_access(input string name, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp);
    logic [31:0] e;
    check({name, "_hold"}, io_bus.uart_rd_data, prev_rd);
    exp_q.push_back(exp);
    bus_cycle(1'b1, wr, addr, wd, 1'b1);
    e = exp_q.pop_front();
    check(name, io_bus.uart_rd_data, e);
    prev_rd = e;
  endtask

  task automatic bus_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus_access(name, 1'b0, addr, 32'h0, exp);
  endtask

  // Sample one TX frame cycle by cycle; gap = idle cycles before the start bit
  task automatic capture_frame(input int limit, output logic [7:0] data,
                               output int gap, output logic ok);
    int n;
    logic [9:0] fr;
    n = 0;
    data = '0;
    fr = '0;
    do begin
      tick();
      n++;
    end while (uart_tx === 1'b1 && n < limit);
    if (uart_tx !== 1'b0) begin
      gap = -1;
      ok = 1'b0;
      return;
    end
    gap = n - 1;
    ok = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT; c++) begin
        if (!(b == 0 && c == 0)) tick();
        if (c == 0) fr[b] = uart_tx;
        else if (uart_tx !== fr[b]) ok = 1'b0;
      end
    end
    if (fr[0] !== 1'b0 || fr[9] !== 1'b1) ok = 1'b0;
    data = fr[8:1];
  endtask

  task automatic check_frame(input string name, input int limit, input logic want_gap0);
    logic [7:0] data;
    logic [7:0] e;
    int gap;
    logic ok;
    capture_frame(limit, data, gap, ok);
    if (gap < 0) begin
      check({name, "_start"}, {31'b0, uart_tx}, 32'h0);
    end else begin
      e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
      check({name, "_data"}, {24'b0, data}, {24'b0, e});
      check({name, "_shape"}, {31'b0, ok}, 32'h1);
      if (want_gap0) check({name, "_gap"}, gap, 0);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) tick();
    end
    uart_rx = stop;
    repeat (BIT) tick();
    uart_rx = 1'b1;
    repeat (4) tick();
  endtask

  task automatic count_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    rst = 1'b0;
    uart_rx = 1'b1;
    io_bus.rd_en = 1'b0;
    io_bus.wr_en = 1'b0;
    io_bus.cs = 1'b0;
    io_bus.address = '0;
    io_bus.wr_data = '0;
    prev_rd = '0;

    vecs[0]  = mk(1'b1, 1'b1, 32'h4,   32'h0,        32'h2,   "status_reset");
    vecs[1]  = mk(1'b1, 1'b1, 32'h8,   32'h0,        32'd868, "baud_reset");
    vecs[2]  = mk(1'b1, 1'b1, 32'hC,   32'h0,        32'h0,   "ctrl_read");
    vecs[3]  = mk(1'b1, 1'b1, 32'h0,   32'h0,        32'h0,   "data_reset");
    vecs[4]  = mk(1'b0, 1'b1, 32'h8,   32'h2,        32'h0,   "");
    vecs[5]  = mk(1'b1, 1'b1, 32'h8,   32'h0,        32'h4,   "baud_clamp2");
    vecs[6]  = mk(1'b0, 1'b1, 32'h8,   32'h0001_0005, 32'h0,  "");
    vecs[7]  = mk(1'b1, 1'b1, 32'h108, 32'h0,        32'h5,   "baud_alias");
    vecs[8]  = mk(1'b0, 1'b0, 32'h8,   32'd100,      32'h0,   "");
    vecs[9]  = mk(1'b1, 1'b1, 32'h8,   32'h0,        32'h5,   "baud_no_cs");
    vecs[10] = mk(1'b0, 1'b1, 32'h8,   32'h3,        32'h0,   "");
    vecs[11] = mk(1'b1, 1'b1, 32'h8,   32'h0,        32'h4,   "baud_clamp3");
    vecs[12] = mk(1'b0, 1'b1, 32'h8,   32'd16,       32'h0,   "");
    vecs[13] = mk(1'b1, 1'b1, 32'h8,   32'h0,        32'd16,  "baud_16");
    vecs[14] = mk(1'b0, 1'b1, 32'hC,   32'hFFFF_FFFF, 32'h0,  "");
    vecs[15] = mk(1'b1, 1'b1, 32'h4,   32'h0,        32'h2,   "status_ctrl");

    repeat (3) tick();
    check("reset_tx", {31'b0, uart_tx}, 32'h1);
    check("reset_rd", io_bus.uart_rd_data, 32'h0);
    rst = 1'b1;
    tick();

    // Register map vectors
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rd) bus_read(vecs[i].name, vecs[i].addr, vecs[i].exp);
      else bus_cycle(1'b0, 1'b1, vecs[i].addr, vecs[i].wdata, vecs[i].cs);
    end

    // Simultaneous read and write returns the pre-write value
    bus_access("rw_baud", 1'b1, 32'h8, 32'd20, 32'd16);
    bus_read("rw_after", 32'h8, 32'd20);
    bus_write(32'h8, 32'd16);

    // Single TX frame, then busy through the last stop clock
    tx_q.push_back(8'hA5);
    bus_write(32'h0, 32'hA5);
    check_frame("tx_a5", 50, 1'b1);
    bus_read("status_stop_end", 32'h4, 32'h10);
    bus_read("status_tx_idle", 32'h4, 32'h02);

    // FIFO full: ten back-to-back writes, nine frames with no gap
    for (int i = 0; i < 9; i++) tx_q.push_back(8'(i));
    fork
      begin
        for (int i = 0; i < 10; i++) bus_write(32'h0, i);
        bus_read("status_full", 32'h4, 32'h11);
      end
      begin
        for (int f = 0; f < 9; f++) check_frame($sformatf("frame%0d", f), 50, f > 0);
      end
    join
    count_low(40, lows);
    check("no_extra_frame", lows, 0);
    bus_read("status_fifo_done", 32'h4, 32'h02);

    // RX byte and read latency
    send_rx(8'h3C, 1'b1);
    bus_read("status_rx", 32'h4, 32'h06);
    bus_read("data_rx", 32'h0, 32'h3C);
    bus_read("status_rx_clr", 32'h4, 32'h02);

    // Overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read("status_ovr", 32'h4, 32'h0E);
    bus_read("data_ovr", 32'h0, 32'h22);
    bus_read("status_ovr_keep", 32'h4, 32'h0A);
    bus_write(32'hC, 32'h1);
    bus_read("status_ovr_clr", 32'h4, 32'h02);

    // Framing error discards the byte
    send_rx(8'h55, 1'b0);
    bus_read("status_frame_err", 32'h4, 32'h02);
    bus_read("data_frame_err", 32'h0, 32'h22);

    // Glitch on rx is ignored, a following real frame is received
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (40) tick();
    bus_read("status_glitch", 32'h4, 32'h02);
    send_rx(8'h81, 1'b1);
    bus_read("data_after_glitch", 32'h0, 32'h81);

    // Reset mid-frame
    bus_write(32'h0, 32'h00);
    bus_write(32'h0, 32'h01);
    repeat (40) tick();
    check("pre_reset_tx_low", {31'b0, uart_tx}, 32'h0);
    rst = 1'b0;
    #1;
    check("reset_async_tx", {31'b0, uart_tx}, 32'h1);
    check("reset_async_rd", io_bus.uart_rd_data, 32'h0);
    prev_rd = '0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    bus_read("status_after_rst", 32'h4, 32'h02);
    bus_read("baud_after_rst", 32'h8, 32'd868);
    count_low(40, lows);
    check("no_tx_after_rst", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
